// File: rtl/psum_arb_pkg.sv
// Shared types and beat geometry for the PEB psum arbiter.
package psum_arb_pkg;

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} arb_state_e;

   localparam int unsigned PSUM_WIDTH = 32;
   localparam int unsigned NUM_WORD   = 16;
   localparam int unsigned DW         = PSUM_WIDTH * NUM_WORD;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate requests by ptr, take the lowest set bit, rotate the index back.
module rr_pick #(
   parameter int unsigned N  = 16,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_onehot,
   output logic [IW-1:0] gnt_id,
   output logic          any
);

   localparam int unsigned SW = IW + 1;

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [IW-1:0]  pos;
   logic [SW-1:0]  sum;

   always_comb begin
      dbl = {req, req} >> ptr;
      rot = dbl[N-1:0];
      pos = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) pos = IW'(i);
      end
      // explicit wrap keeps non-power-of-2 N legal
      sum = {1'b0, pos} + {1'b0, ptr};
      if (sum >= SW'(N)) sum = sum - SW'(N);
      gnt_id     = sum[IW-1:0];
      any        = |req;
      gnt_onehot = any ? (N'(1) << gnt_id) : '0;
   end

endmodule

// File: rtl/peb_psum_arb.sv
// Packet-locked round-robin arbiter sharing one GB psum write port among NUM_PEB PE blocks.
module peb_psum_arb
   import psum_arb_pkg::*;
#(
   parameter int unsigned NUM_PEB  = 16,
   parameter int unsigned ID_WIDTH = $clog2(NUM_PEB)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_PEB-1:0]    CFGARB_mask,
   input  logic [NUM_PEB-1:0]    PEBPSUM_val,
   input  logic [NUM_PEB-1:0]    PEBPSUM_last,
   input  logic [NUM_PEB*DW-1:0] PEBPSUM_data,
   output logic [NUM_PEB-1:0]    PSUMPEB_rdy,
   output logic                  PSUMGB_val,
   output logic [DW-1:0]         PSUMGB_data,
   output logic [ID_WIDTH-1:0]   PSUMGB_id,
   output logic                  PSUMGB_last,
   input  logic                  GBPSUM_rdy,
   output logic                  ARB_busy
);

   arb_state_e            state, state_nxt;
   logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
   logic [ID_WIDTH-1:0]   owner, owner_nxt;

   logic [NUM_PEB-1:0]    cand_c;
   logic [NUM_PEB-1:0]    win_oh_c;
   logic [ID_WIDTH-1:0]   win_id_c;
   logic                  win_any_c;
   logic                  slot_free_c;
   logic [NUM_PEB-1:0]    rdy_c;
   logic [ID_WIDTH-1:0]   src_c;
   logic                  acc_c;
   logic [DW-1:0]         beat_c;
   logic                  beat_last_c;
   logic                  val_nxt_c;

   function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] v);
      return (32'(v) == NUM_PEB - 1) ? '0 : v + ID_WIDTH'(1);
   endfunction

   assign cand_c      = PEBPSUM_val & CFGARB_mask;
   assign slot_free_c = ~PSUMGB_val | GBPSUM_rdy;

   rr_pick #(.N(NUM_PEB), .IW(ID_WIDTH)) u_pick (
      .req        (cand_c),
      .ptr        (rr_ptr),
      .gnt_onehot (win_oh_c),
      .gnt_id     (win_id_c),
      .any        (win_any_c)
   );

   // grant, accept and next-state decode
   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      owner_nxt  = owner;
      rdy_c      = '0;
      src_c      = win_id_c;
      unique case (state)
         IDLE: begin
            rdy_c = win_oh_c & {NUM_PEB{slot_free_c & win_any_c}};
            src_c = win_id_c;
         end
         LOCK: begin
            rdy_c = (NUM_PEB'(1) << owner) & {NUM_PEB{slot_free_c}};
            src_c = owner;
         end
         default: ;
      endcase
      acc_c       = |(rdy_c & PEBPSUM_val);
      beat_c      = PEBPSUM_data[32'(src_c)*DW +: DW];
      beat_last_c = PEBPSUM_last[src_c];
      if (acc_c) begin
         if (beat_last_c) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = wrap_inc(src_c);
         end else if (state == IDLE) begin
            state_nxt = LOCK;
            owner_nxt = win_id_c;
         end
      end
      val_nxt_c = acc_c ? 1'b1 : (GBPSUM_rdy ? 1'b0 : PSUMGB_val);
   end

   assign PSUMPEB_rdy = rdy_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         owner       <= '0;
         PSUMGB_val  <= 1'b0;
         PSUMGB_data <= '0;
         PSUMGB_id   <= '0;
         PSUMGB_last <= 1'b0;
         ARB_busy    <= 1'b0;
      end else begin
         state      <= state_nxt;
         rr_ptr     <= rr_ptr_nxt;
         owner      <= owner_nxt;
         PSUMGB_val <= val_nxt_c;
         ARB_busy   <= (state_nxt == LOCK) | val_nxt_c;
         if (acc_c) begin
            PSUMGB_data <= beat_c;
            PSUMGB_id   <= src_c;
            PSUMGB_last <= beat_last_c;
         end
      end
   end

endmodule

// File: tb/tb_peb_psum_arb.sv
// Directed self-checking bench for peb_psum_arb.
module tb_peb_psum_arb;
   import psum_arb_pkg::*;

   localparam int unsigned NP = 16;
   localparam int unsigned IW = 4;

   logic               clk;
   logic               rst_n;
   logic [NP-1:0]      mask;
   logic [NP-1:0]      pval;
   logic [NP-1:0]      plast;
   logic [NP*DW-1:0]   pdata;
   logic [NP-1:0]      prdy;
   logic               gval;
   logic [DW-1:0]      gdata;
   logic [IW-1:0]      gid;
   logic               glast;
   logic               grdy;
   logic               busy;

   int passes = 0;
   int total  = 0;

   logic               hold_prev = 1'b0;
   logic [DW-1:0]      prev_data;
   logic [IW-1:0]      prev_id;
   logic               prev_last;

   peb_psum_arb #(.NUM_PEB(NP), .ID_WIDTH(IW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .CFGARB_mask  (mask),
      .PEBPSUM_val  (pval),
      .PEBPSUM_last (plast),
      .PEBPSUM_data (pdata),
      .PSUMPEB_rdy  (prdy),
      .PSUMGB_val   (gval),
      .PSUMGB_data  (gdata),
      .PSUMGB_id    (gid),
      .PSUMGB_last  (glast),
      .GBPSUM_rdy   (grdy),
      .ARB_busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk(input int p, input int k);
      logic [DW-1:0] r;
      for (int w = 0; w < int'(NUM_WORD); w++) r[w*32 +: 32] = 32'(p*256 + k*16 + w + 1);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_peb(input int i, input logic v, input logic l, input int k);
      pval[i]           = v;
      plast[i]          = l;
      pdata[DW*i +: DW] = mk(i, k);
   endtask

   task automatic chk_out(input string tag, input int id, input int k, input logic l);
      chk({tag, "_val"},  DW'(gval),  DW'(1));
      chk({tag, "_id"},   DW'(gid),   DW'(id));
      chk({tag, "_data"}, gdata,      mk(id, k));
      chk({tag, "_last"}, DW'(glast), DW'(l));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // continuous invariants: one-hot-or-zero ready, stable output under backpressure
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_prev <= 1'b0;
      end else begin
         chk("rdy_onehot0", DW'($onehot0(prdy)), DW'(1));
         if (hold_prev) begin
            chk("stall_data", gdata, prev_data);
            chk("stall_id",   DW'(gid), DW'(prev_id));
            chk("stall_last", DW'(glast), DW'(prev_last));
            chk("stall_val",  DW'(gval), DW'(1));
         end
         hold_prev <= gval & ~grdy;
         prev_data <= gdata;
         prev_id   <= gid;
         prev_last <= glast;
      end
   end

   initial begin
      rst_n = 1'b0;
      mask  = '1;
      pval  = '0;
      plast = '0;
      pdata = '0;
      grdy  = 1'b1;
      tick();
      chk("rst_rdy",  DW'(prdy),  '0);
      chk("rst_val",  DW'(gval),  '0);
      chk("rst_data", gdata,      '0);
      chk("rst_id",   DW'(gid),   '0);
      chk("rst_last", DW'(glast), '0);
      chk("rst_busy", DW'(busy),  '0);
      rst_n = 1'b1;
      tick();

      // single-beat packet from PEB3
      set_peb(3, 1'b1, 1'b1, 0);
      #1 chk("t1_rdy", DW'(prdy), DW'(16'h0008));
      tick();
      chk_out("t1", 3, 0, 1'b1);
      chk("t1_rr", DW'(dut.rr_ptr), DW'(4));
      chk("t1_busy", DW'(busy), DW'(1));
      pval = '0;
      tick();
      chk("t1_idle_val", DW'(gval), '0);

      // all PEBs streaming single-beat packets: 0..15,0 back to back
      do_reset();
      for (int i = 0; i < int'(NP); i++) set_peb(i, 1'b1, 1'b1, 0);
      for (int n = 0; n < 17; n++) begin
         #1 chk("t2_rdy", DW'(prdy), DW'(1) << (n % 16));
         tick();
         chk_out("t2", n % 16, 0, 1'b1);
      end
      pval = '0;
      tick();
      chk("t2_drain", DW'(gval), '0);

      // PEB5 4-beat packet holds off PEB6
      set_peb(6, 1'b1, 1'b1, 0);
      for (int k = 0; k < 4; k++) begin
         set_peb(5, 1'b1, (k == 3), k);
         #1 chk("t3_rdy", DW'(prdy), DW'(16'h0020));
         tick();
         chk_out("t3", 5, k, (k == 3));
      end
      pval[5] = 1'b0;
      #1 chk("t3_rdy6", DW'(prdy), DW'(16'h0040));
      tick();
      chk_out("t3_6", 6, 0, 1'b1);
      pval = '0;
      tick();

      // GB stall for three cycles in the middle of a PEB8 packet
      set_peb(8, 1'b1, 1'b0, 0);
      #1 chk("t4_rdy0", DW'(prdy), DW'(16'h0100));
      tick();
      chk_out("t4_b0", 8, 0, 1'b0);
      set_peb(8, 1'b1, 1'b0, 1);
      grdy = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1 chk("t4_stall_rdy", DW'(prdy), '0);
         tick();
         chk_out("t4_hold", 8, 0, 1'b0);
      end
      grdy = 1'b1;
      for (int k = 1; k < 4; k++) begin
         set_peb(8, 1'b1, (k == 3), k);
         #1 chk("t4_rdy", DW'(prdy), DW'(16'h0100));
         tick();
         chk_out("t4", 8, k, (k == 3));
      end
      pval = '0;
      tick();

      // masked PEB0 never wins; masking the owner mid-packet does not break the lock
      mask = 16'hFFFE;
      set_peb(0, 1'b1, 1'b1, 0);
      for (int s = 0; s < 3; s++) begin
         #1 chk("t5_masked", DW'(prdy), '0);
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         set_peb(2, 1'b1, (k == 2), k);
         #1 chk("t5_rdy2", DW'(prdy), DW'(16'h0004));
         tick();
         chk_out("t5", 2, k, (k == 2));
         mask = 16'hFFFA;
      end
      pval[2] = 1'b0;
      #1 chk("t5_after", DW'(prdy), '0);
      pval = '0;
      mask = '1;
      tick();

      // reset asserted while PEB10 owns the port
      set_peb(10, 1'b1, 1'b0, 0);
      #1 chk("t6_rdy", DW'(prdy), DW'(16'h0400));
      tick();
      chk("t6_lock", DW'(dut.state), DW'(LOCK));
      chk("t6_busy", DW'(busy), DW'(1));
      rst_n = 1'b0;
      pval  = '0;
      #1;
      chk("t6_val",   DW'(gval),  '0);
      chk("t6_data",  gdata,      '0);
      chk("t6_id",    DW'(gid),   '0);
      chk("t6_last",  DW'(glast), '0);
      chk("t6_busy0", DW'(busy),  '0);
      chk("t6_rdy0",  DW'(prdy),  '0);
      chk("t6_state", DW'(dut.state), DW'(IDLE));
      chk("t6_rr",    DW'(dut.rr_ptr), '0);
      tick();
      rst_n = 1'b1;
      tick();
      set_peb(3, 1'b1, 1'b1, 1);
      #1 chk("t6_rdy3", DW'(prdy), DW'(16'h0008));
      tick();
      chk_out("t6_post", 3, 1, 1'b1);
      chk("t6_rr4", DW'(dut.rr_ptr), DW'(4));
      pval = '0;
      tick();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
